// File: rtl/bound_flasher_pkg.sv
// Shared types for the bound flasher: FSM states, segment ids
// and the per-segment level target.
package bound_flasher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        SEG0 = 3'd0,
        SEG1 = 3'd1,
        SEG2 = 3'd2,
        SEG3 = 3'd3,
        SEG4 = 3'd4,
        SEG5 = 3'd5
    } seg_e;

    function automatic int seg_target(
        input seg_e s,
        input int   num_led,
        input int   peak1,
        input int   peak2,
        input int   trough
    );
        case (s)
            SEG0:    seg_target = peak1 + 1;
            SEG1:    seg_target = 0;
            SEG2:    seg_target = peak2 + 1;
            SEG3:    seg_target = trough;
            SEG4:    seg_target = num_led;
            SEG5:    seg_target = 0;
            default: seg_target = 0;
        endcase
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Divides the clock down to one step tick every STEP_DIV clocks;
// clr restarts the count so the first tick lands STEP_DIV clocks later.
module step_prescaler #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/param_bound_flasher.sv
// Thermometer lamp flasher: six up/down segments with kickback on
// flick at the trough or at zero, optional auto-repeat.
module param_bound_flasher
    import bound_flasher_pkg::*;
#(
    parameter int NUM_LED  = 16,
    parameter int PEAK1    = 5,
    parameter int PEAK2    = 10,
    parameter int TROUGH   = 5,
    parameter int STEP_DIV = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flick,
    input  logic                           repeat_en,
    output logic [NUM_LED-1:0]             LED,
    output logic [$clog2(NUM_LED+1)-1:0]   level,
    output logic [1:0]                     state,
    output logic [2:0]                     seg,
    output logic                           busy,
    output logic                           cycle_done
);

    localparam int LW = $clog2(NUM_LED + 1);
    localparam logic [LW-1:0] TROUGH_L = LW'(TROUGH);

    state_e        st_q, st_d;
    seg_e          seg_q, seg_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic [LW-1:0] lvl_step, tgt;
    logic          done_q, done_d;
    logic          restart, pre_clr, pre_tick, tick, kick;

    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_pre (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .tick  (pre_tick)
    );

    assign pre_clr = (st_q == ST_IDLE) || restart;
    assign tick    = (st_q == ST_IDLE) || pre_tick;

    always_comb begin
        st_d     = st_q;
        seg_d    = seg_q;
        lvl_d    = lvl_q;
        done_d   = 1'b0;
        restart  = 1'b0;
        tgt      = LW'(seg_target(seg_q, NUM_LED, PEAK1, PEAK2, TROUGH));
        lvl_step = (st_q == ST_DOWN) ? lvl_q - LW'(1) : lvl_q + LW'(1);
        kick     = flick && ((lvl_step == TROUGH_L) || (lvl_step == '0));
        if (tick) begin
            unique case (st_q)
                ST_IDLE: begin
                    lvl_d = '0;
                    if (flick) begin
                        st_d  = ST_UP;
                        seg_d = SEG0;
                        lvl_d = LW'(1);
                    end
                end
                ST_UP: begin
                    lvl_d = lvl_step;
                    if (lvl_step == tgt) begin
                        seg_d = seg_e'(seg_q + 3'd1);
                        st_d  = ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    lvl_d = lvl_step;
                    // Kickback wins over segment advance on the same tick
                    if (kick) begin
                        seg_d = seg_e'(seg_q - 3'd1);
                        st_d  = ST_UP;
                    end else if (lvl_step == tgt) begin
                        if (seg_q == SEG5) begin
                            done_d  = 1'b1;
                            seg_d   = SEG0;
                            restart = repeat_en;
                            st_d    = repeat_en ? ST_UP : ST_IDLE;
                        end else begin
                            seg_d = seg_e'(seg_q + 3'd1);
                            st_d  = ST_UP;
                        end
                    end
                end
                default: begin
                    st_d  = ST_IDLE;
                    seg_d = SEG0;
                    lvl_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            seg_q  <= SEG0;
            lvl_q  <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            seg_q  <= seg_d;
            lvl_q  <= lvl_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        LED = '0;
        for (int i = 0; i < NUM_LED; i++) begin
            LED[i] = (i < int'(lvl_q));
        end
    end

    assign level      = lvl_q;
    assign state      = st_q;
    assign seg        = seg_q;
    assign busy       = (st_q != ST_IDLE);
    assign cycle_done = done_q;

endmodule

// File: tb/tb_param_bound_flasher.sv
// Directed bench for param_bound_flasher: full cycle, kickbacks,
// repeat, prescaler and reset behaviour.
module tb_param_bound_flasher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flick = 1'b0;
    logic        repeat_en = 1'b0;
    logic        flick3 = 1'b0;
    logic [15:0] led, led3;
    logic [4:0]  level, level3;
    logic [1:0]  state, state3;
    logic [2:0]  seg, seg3;
    logic        busy, busy3, done, done3;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int tgt_q[$];

    always #5 clk = ~clk;

    param_bound_flasher dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flick      (flick),
        .repeat_en  (repeat_en),
        .LED        (led),
        .level      (level),
        .state      (state),
        .seg        (seg),
        .busy       (busy),
        .cycle_done (done)
    );

    param_bound_flasher #(.STEP_DIV(3)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flick      (flick3),
        .repeat_en  (1'b0),
        .LED        (led3),
        .level      (level3),
        .state      (state3),
        .seg        (seg3),
        .busy       (busy3),
        .cycle_done (done3)
    );

    function automatic logic [15:0] therm(input int n);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Expected level after each tick, walking the target list from 0
    task automatic build_exp();
        int lvl;
        lvl = 0;
        exp_q = {};
        foreach (tgt_q[k]) begin
            while (lvl != tgt_q[k]) begin
                lvl = (tgt_q[k] > lvl) ? lvl + 1 : lvl - 1;
                exp_q.push_back(lvl);
            end
        end
    endtask

    task automatic step(input logic f);
        flick = f;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        flick = 1'b1;
        #1;
        n_checks++;
        if (led !== 16'h0 || level !== 5'd0 || state !== 2'd0 || seg !== 3'd0
            || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: led=%h lvl=%0d st=%0d seg=%0d busy=%b done=%b",
                     led, level, state, seg, busy, done);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (led !== 16'h0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_flick: led=%h st=%0d want 0/0", led, state);
        end
        flick = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            n_checks++;
            if (led !== 16'h0 || state !== 2'd0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: led=%h st=%0d busy=%b want 0/0/0",
                         i, led, state, busy);
            end
        end
    endtask

    task automatic test_single_cycle();
        int n_done;
        n_done = 0;
        tgt_q = {6, 0, 11, 5, 16, 0};
        build_exp();
        for (int i = 0; i < exp_q.size(); i++) begin
            step(i == 0);
            if (done === 1'b1) n_done++;
            n_checks++;
            if (level !== 5'(exp_q[i]) || led !== therm(exp_q[i])) begin
                n_fail++;
                $display("FAIL single_level[%0d]: level=%0d led=%h want %0d",
                         i, level, led, exp_q[i]);
            end
            if (i == 0 || i == 5 || i == 22 || i == 28) begin
                n_checks++;
                if ({state, seg} !== ((i == 0) ? 5'b01_000 : (i == 5) ? 5'b10_001 :
                                      (i == 22) ? 5'b10_011 : 5'b01_100)) begin
                    n_fail++;
                    $display("FAIL single_seg[%0d]: state=%0d seg=%0d", i, state, seg);
                end
            end
        end
        n_checks++;
        if (n_done != 1 || state !== 2'd0 || busy !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL single_end: pulses=%0d st=%0d busy=%b done=%b want 1/0/0/1",
                     n_done, state, busy, done);
        end
        step(1'b0);
        n_checks++;
        if (done !== 1'b0 || level !== 5'd0 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL single_idle: done=%b lvl=%0d st=%0d want 0/0/0",
                     done, level, state);
        end
    endtask

    task automatic test_kick_seg3();
        int n_done;
        n_done = 0;
        tgt_q = {6, 0, 11, 5, 11, 5, 16, 0};
        build_exp();
        for (int i = 0; i < exp_q.size(); i++) begin
            step(i == 0 || i == 28);
            if (done === 1'b1) n_done++;
            n_checks++;
            if (level !== 5'(exp_q[i])) begin
                n_fail++;
                $display("FAIL kick3_level[%0d]: level=%0d want %0d", i, level, exp_q[i]);
            end
            if (i == 28) begin
                n_checks++;
                if (state !== 2'd1 || seg !== 3'd2) begin
                    n_fail++;
                    $display("FAIL kick3_seg: state=%0d seg=%0d want 1/2", state, seg);
                end
            end
        end
        n_checks++;
        if (n_done != 1 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL kick3_end: pulses=%0d st=%0d want 1/0", n_done, state);
        end
        step(1'b0);
    endtask

    task automatic test_kick_seg5();
        int n_done;
        n_done = 0;
        tgt_q = {6, 0, 11, 5, 16, 0, 16, 0};
        build_exp();
        for (int i = 0; i < exp_q.size(); i++) begin
            step(i == 0 || i == 55);
            if (done === 1'b1) n_done++;
            n_checks++;
            if (level !== 5'(exp_q[i])) begin
                n_fail++;
                $display("FAIL kick5_level[%0d]: level=%0d want %0d", i, level, exp_q[i]);
            end
            if (i == 55) begin
                n_checks++;
                if (state !== 2'd1 || seg !== 3'd4 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL kick5_seg: state=%0d seg=%0d done=%b want 1/4/0",
                             state, seg, done);
                end
            end
        end
        n_checks++;
        if (n_done != 1 || state !== 2'd0) begin
            n_fail++;
            $display("FAIL kick5_end: pulses=%0d st=%0d want 1/0", n_done, state);
        end
        step(1'b0);
    endtask

    task automatic test_repeat();
        int n_done;
        repeat_en = 1'b1;
        tgt_q = {6, 0, 11, 5, 16, 0};
        build_exp();
        for (int i = 0; i < exp_q.size(); i++) begin
            step(i == 0);
        end
        n_checks++;
        if (done !== 1'b1 || state !== 2'd1 || seg !== 3'd0 || level !== 5'd0) begin
            n_fail++;
            $display("FAIL repeat_wrap: done=%b st=%0d seg=%0d lvl=%0d want 1/1/0/0",
                     done, state, seg, level);
        end
        step(1'b0);
        n_checks++;
        if (level !== 5'd1 || state !== 2'd1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL repeat_restart: lvl=%0d st=%0d done=%b want 1/1/0",
                     level, state, done);
        end
        repeat_en = 1'b0;
        n_done = 0;
        for (int i = 1; i < exp_q.size(); i++) begin
            step(1'b0);
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 1 || state !== 2'd0 || level !== 5'd0) begin
            n_fail++;
            $display("FAIL repeat_stop: pulses=%0d st=%0d lvl=%0d want 1/0/0",
                     n_done, state, level);
        end
        step(1'b0);
    endtask

    task automatic test_prescaler();
        flick3 = 1'b1;
        @(posedge clk); #1;
        flick3 = 1'b0;
        n_checks++;
        if (level3 !== 5'd1 || busy3 !== 1'b1) begin
            n_fail++;
            $display("FAIL div3_start: lvl=%0d busy=%b want 1/1", level3, busy3);
        end
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            n_checks++;
            if (level3 !== 5'(1 + k / 3)) begin
                n_fail++;
                $display("FAIL div3_level[%0d]: lvl=%0d want %0d", k, level3, 1 + k / 3);
            end
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (level3 !== 5'd0 || state3 !== 2'd0) begin
            n_fail++;
            $display("FAIL div3_reset: lvl=%0d st=%0d want 0/0", level3, state3);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 33; i++) step(i == 0);
        n_checks++;
        if (level !== 5'd9 || seg !== 3'd4 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_pre: lvl=%0d seg=%0d st=%0d want 9/4/1", level, seg, state);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (led !== 16'h0 || level !== 5'd0 || busy !== 1'b0 || seg !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_async: led=%h lvl=%0d busy=%b seg=%0d want 0", led, level, busy, seg);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            n_checks++;
            if (done !== 1'b0 || state !== 2'd0 || level !== 5'd0) begin
                n_fail++;
                $display("FAIL mid_after[%0d]: done=%b st=%0d lvl=%0d want 0/0/0",
                         i, done, state, level);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_kick_seg3();
        test_kick_seg5();
        test_repeat();
        test_prescaler();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_bound_flasher.md
PARAM_BOUND_FLASHER -- requirements
Module: param_bound_flasher

Interface
REQ-001 Parameter NUM_LED, default 16: lamp count; legal range 4..64.
REQ-002 Parameter PEAK1, default 5: highest lamp index lit in segment 0.
REQ-003 Parameter PEAK2, default 10: highest lamp index lit in segment 2.
REQ-004 Parameter TROUGH, default 5: lowest lamp index turned off in segment 3; also the upper kick point. Legal values satisfy 0 < TROUGH <= PEAK1 < PEAK2 < NUM_LED-1.
REQ-005 Parameter STEP_DIV, default 1: clocks per lamp step; legal range 1..65535.
REQ-006 clk  in  1  single system clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 flick  in  1  start / kickback request; synchronous, sampled only on step ticks.
REQ-009 repeat_en  in  1  when 1, a finished cycle restarts immediately instead of going idle.
REQ-010 LED  out  NUM_LED  thermometer lamp vector: LED[i] = 1 iff i < level.
REQ-011 level  out  $clog2(NUM_LED+1)  number of lamps lit.
REQ-012 state  out  2  0 IDLE, 1 UP, 2 DOWN.
REQ-013 seg  out  3  current segment, 0..5.
REQ-014 busy  out  1  high whenever state != IDLE.
REQ-015 cycle_done  out  1  one-clock pulse at the end of segment 5.

Function
REQ-016 Step tick: in IDLE, every clock is a tick; otherwise a tick fires once every STEP_DIV clocks, with the prescaler cleared on every start or restart.
REQ-017 IDLE with flick=1 at a tick -> UP, seg 0, level 1 on the same edge; flick=0 -> remain IDLE with level 0.
REQ-018 Segment targets:
- seg0: UP to PEAK1+1
- seg1: DOWN to 0
- seg2: UP to PEAK2+1
- seg3: DOWN to TROUGH
- seg4: UP to NUM_LED
- seg5: DOWN to 0
REQ-019 Each tick in UP increments level by 1 and each tick in DOWN decrements it by 1; level never leaves 0..NUM_LED.
REQ-020 Target reached: the tick that makes level equal the target also advances seg to seg+1 and sets state to that segment's direction, on the same edge.
REQ-021 Kickback: in seg 1, 3 or 5, if a DOWN tick makes level equal TROUGH or 0 and flick=1 on that tick, then next state is UP and seg becomes seg-1. The lamps re-climb to that segment's peak, then continue per REQ-018.
REQ-022 Kickback takes priority over segment advance (REQ-020) on the same tick.
REQ-023 End of seg5 (level reaches 0 without a kick): cycle_done = 1 for one clock. If repeat_en = 1, go to seg 0 UP with level 0, and the next tick gives level 1. Otherwise go to IDLE.
REQ-024 flick is ignored in UP and on non-kick-point DOWN ticks; flick pulse width is irrelevant beyond its tick sampling.
REQ-025 repeat_en is sampled only at the end of seg5.

Reset
REQ-026 rst_n=0 asynchronously forces:
- LED=0, level=0, state=IDLE, seg=0
- busy=0, cycle_done=0
- prescaler=0
REQ-027 Reset mid-cycle aborts the cycle with no cycle_done. After release, the block waits for a fresh flick.

Structure
REQ-028 Package bound_flasher_pkg holds the state enum (IDLE/UP/DOWN), the segment enum (SEG0..SEG5) and a function returning the target level per segment.
REQ-029 Sub-module step_prescaler (parameter STEP_DIV; ports clk, rst_n, clr, tick) generates the step tick.
REQ-030 LED is decoded combinationally from registered level. All other outputs are registered or decoded from registered state.

Verification (NUM_LED=16, PEAK1=5, PEAK2=10, TROUGH=5, STEP_DIV=1 unless noted)
REQ-031 flick pulse while rst_n=0, then release -> LED stays 0, state IDLE.
REQ-032 Single flick in IDLE, repeat_en=0, no further flick:
- level sequence 1..6, 5..0, 1..11, 10..5, 6..16, 15..0 (56 steps)
- cycle_done pulses once, then IDLE.
REQ-033 flick=1 on the tick where level reaches 5 in seg3 -> seg2 UP, level 6..11, then seg3 resumes down to 5.
REQ-034 flick=1 on the tick where level reaches 0 in seg5 -> seg4 UP, level 1..16, then seg5 down to 0 and cycle_done.
REQ-035 repeat_en=1 -> after cycle_done, level 1 on the next clock without flick. STEP_DIV=3 -> level changes exactly every 3rd clock.
REQ-036 rst_n asserted at level 9 in seg4 -> LED=0 asynchronously, no cycle_done, IDLE after release.
